// File: rtl/uart_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg : shared types, constants and helpers for uart_tx_scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_NEXT      = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] GNT_CNT = 2'b01;
  localparam logic [1:0] GNT_MSG = 2'b10;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if : byte handshake between scheduler and UART shifter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_data, output tx_start, input tx_busy);
  modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2 : two-way round-robin arbiter, history advances on update
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import uart_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic [1:0] rr_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = GNT_CNT;
      2'b10:   gnt = GNT_MSG;
      2'b11:   gnt = (rr_last == GNT_MSG) ? GNT_CNT : GNT_MSG;
      default: gnt = 2'b00;
    endcase
  end

  // Message as last owner lets the counter win the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= GNT_MSG;
    end else if (update && (gnt != 2'b00)) begin
      rr_last <= gnt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler : frames counter hex dumps and a ROM message onto one UART
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int HEX_DIGITS  = 4,
  parameter int SEND_CRLF   = 1,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          cnt_value,
  input  logic                 cnt_en,
  input  logic                 msg_req,
  uart_tx_scheduler_if.master  tx,
  output logic                 sched_busy,
  output logic [1:0]           grant
);

  localparam int           TW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0]   CNT_LAST  = 4'(HEX_DIGITS + 2 * SEND_CRLF - 1);
  localparam logic [3:0]   MSG_LAST  = 4'(MSG_LEN - 1);
  localparam logic [127:0] MSG_ROM   = "HELLO WORLD !!!!";

  state_t          state, state_nxt;
  logic            cnt_pend, msg_pend, msg_req_d;
  logic [15:0]     last_sent, frame_val;
  logic [3:0]      idx;
  logic [TW-1:0]   timer;
  logic [1:0]      arb_gnt;
  logic            arb_update, fire, idx_inc, timer_inc, gnt_clr;
  logic [3:0]      frame_last;
  logic [1:0]      shift;
  logic [3:0]      nib;
  logic [7:0]      cur_byte;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({msg_pend, cnt_pend}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  assign sched_busy = (state != S_IDLE);
  assign frame_last = (grant == GNT_MSG) ? MSG_LAST : CNT_LAST;

  // Most significant nibble goes out first
  assign shift = 2'(HEX_DIGITS - 1) - idx[1:0];
  assign nib   = frame_val[{shift, 2'b00} +: 4];

  always_comb begin
    cur_byte = ASCII_LF;
    if (grant == GNT_MSG) begin
      cur_byte = MSG_ROM[{~idx, 3'b000} +: 8];
    end else if (idx < 4'(HEX_DIGITS)) begin
      cur_byte = nibble_to_ascii(nib);
    end else if (idx == 4'(HEX_DIGITS)) begin
      cur_byte = ASCII_CR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    arb_update = 1'b0;
    fire       = 1'b0;
    idx_inc    = 1'b0;
    timer_inc  = 1'b0;
    gnt_clr    = 1'b0;
    case (state)
      S_IDLE: if (cnt_pend || msg_pend) state_nxt = S_ARB;
      S_ARB: begin
        if (arb_gnt != 2'b00) begin
          arb_update = 1'b1;
          state_nxt  = S_LOAD;
        end else begin
          gnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!tx.tx_busy) begin
          fire      = 1'b1;
          state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx.tx_busy)                        state_nxt = S_WAIT_DONE;
        else if (timer == TW'(ACK_TIMEOUT))    state_nxt = S_LOAD;
        else                                   timer_inc = 1'b1;
      end
      S_WAIT_DONE: if (!tx.tx_busy) state_nxt = S_NEXT;
      S_NEXT: begin
        if (idx == frame_last) begin
          if (cnt_pend || msg_pend) begin
            state_nxt = S_ARB;
          end else begin
            gnt_clr   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          idx_inc   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_pend    <= 1'b0;
      msg_pend    <= 1'b0;
      msg_req_d   <= 1'b0;
      last_sent   <= 16'h0000;
      frame_val   <= 16'h0000;
      idx         <= 4'd0;
      timer       <= '0;
      grant       <= 2'b00;
      tx.tx_data  <= 8'h00;
      tx.tx_start <= 1'b0;
    end else begin
      msg_req_d   <= msg_req;
      tx.tx_start <= 1'b0;

      // A grant snapshots the value, so the clear wins over a fresh set
      if (arb_update && (arb_gnt == GNT_CNT))        cnt_pend <= 1'b0;
      else if (cnt_en && (cnt_value != last_sent))  cnt_pend <= 1'b1;

      if (msg_req && !msg_req_d)                     msg_pend <= 1'b1;
      else if (arb_update && (arb_gnt == GNT_MSG))  msg_pend <= 1'b0;

      if (arb_update) begin
        grant <= arb_gnt;
        idx   <= 4'd0;
        if (arb_gnt == GNT_CNT) begin
          frame_val <= cnt_value;
          last_sent <= cnt_value;
        end
      end
      if (gnt_clr) grant <= 2'b00;

      if (fire) begin
        tx.tx_data  <= cur_byte;
        tx.tx_start <= 1'b1;
        timer       <= '0;
      end
      if (timer_inc) timer <= timer + 1'b1;
      if (idx_inc)   idx   <= idx + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler : directed self-checking bench with a simple UART model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int ACK = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cnt_value;
  logic        cnt_en;
  logic        msg_req;
  logic        sched_busy;
  logic [1:0]  grant;

  uart_tx_scheduler_if tx ();

  uart_tx_scheduler #(
    .MSG_LEN    (16),
    .HEX_DIGITS (4),
    .SEND_CRLF  (1),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_value (cnt_value),
    .cnt_en    (cnt_en),
    .msg_req   (msg_req),
    .tx        (tx),
    .sched_busy(sched_busy),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for 10 cycles from the cycle after tx_start
  int bcnt = 0;
  int n_starts = 0;
  int ignore_at = -1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= 0;
    end else begin
      if (tx.tx_start) n_starts <= n_starts + 1;
      if (tx.tx_start && (n_starts != ignore_at)) bcnt <= 10;
      else if (bcnt != 0)                         bcnt <= bcnt - 1;
    end
  end
  assign tx.tx_busy = (bcnt != 0);

  logic [7:0] cap_d[$];
  logic [1:0] cap_g[$];
  int         cap_c[$];
  int         dbl = 0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx.tx_start) begin
      cap_d.push_back(tx.tx_data);
      cap_g.push_back(grant);
      cap_c.push_back(cyc);
      if (prev_start) dbl <= dbl + 1;
    end
    prev_start <= tx.tx_start;
  end

  int         total = 0;
  int         bad = 0;
  int         rd = 0;
  bit         idle_seen;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_caps(input int n, input int maxc);
    int k;
    k = 0;
    idle_seen = 1'b0;
    while ((cap_d.size() < rd + n) && (k < maxc)) begin
      tick;
      k++;
      if ((cap_d.size() > rd) && (cap_d.size() < rd + n) && !sched_busy) idle_seen = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int split,
                             input logic [1:0] g0, input logic [1:0] g1, input int maxc);
    int n;
    n = exp_q.size();
    wait_caps(n, maxc);
    chk({tag, "_count"}, 32'(cap_d.size() - rd), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (rd + i < cap_d.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), {24'h0, cap_d[rd + i]}, {24'h0, exp_q[i]});
        chk($sformatf("%s_grant%0d", tag, i), {30'h0, cap_g[rd + i]},
            {30'h0, (i < split) ? g0 : g1});
      end
    end
    rd = cap_d.size();
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; (k < 200) && sched_busy; k++) tick;
    chk(tag, {31'h0, sched_busy}, 32'h0);
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    cnt_en    = 1'b0;
    msg_req   = 1'b0;
    cnt_value = 16'h0000;
    tick;
    tick;
    rst = 1'b0;
    tick;
    rd = cap_d.size();
  endtask

  int c0;
  int r5;
  int gap;

  initial begin
    rst       = 1'b1;
    cnt_en    = 1'b0;
    msg_req   = 1'b0;
    cnt_value = 16'h0000;
    tick;
    tick;
    chk("rst_tx_data",    {24'h0, tx.tx_data}, 32'h0);
    chk("rst_tx_start",   {31'h0, tx.tx_start}, 32'h0);
    chk("rst_sched_busy", {31'h0, sched_busy}, 32'h0);
    chk("rst_grant",      {30'h0, grant}, 32'h0);
    rst = 1'b0;
    tick;

    // T1: counter frame for 1A2F; value equal to last_sent raises nothing
    cnt_en = 1'b1;
    repeat (5) tick;
    chk("t1_no_req", {31'h0, sched_busy}, 32'h0);
    cnt_value = 16'h1A2F;
    c0 = cyc;
    exp_q = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    check_frame("t1", 6, 2'b01, 2'b01, 400);
    if (cap_c.size() > 0) chk("t1_latency", 32'(cap_c[0] - c0), 32'd4);
    wait_idle("t1_idle");
    chk("t1_idle_grant", {30'h0, grant}, 32'h0);

    // T2: message frame only
    cnt_en = 1'b0;
    tick;
    msg_req = 1'b1;
    exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
              8'h52, 8'h4C, 8'h44, 8'h20, 8'h21, 8'h21, 8'h21, 8'h21};
    check_frame("t2", 16, 2'b10, 2'b10, 600);
    msg_req = 1'b0;
    wait_idle("t2_idle");

    // T3: simultaneous requests after reset, counter first, no idle gap
    do_reset;
    cnt_en    = 1'b1;
    cnt_value = 16'h0055;
    msg_req   = 1'b1;
    exp_q = '{8'h30, 8'h30, 8'h35, 8'h35, 8'h0D, 8'h0A,
              8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
              8'h52, 8'h4C, 8'h44, 8'h20, 8'h21, 8'h21, 8'h21, 8'h21};
    check_frame("t3", 6, 2'b01, 2'b10, 800);
    chk("t3_no_idle", {31'h0, idle_seen}, 32'h0);
    msg_req = 1'b0;
    wait_idle("t3_idle");

    // T4: value changes mid-frame; frame uses the snapshot, then a new frame
    cnt_value = 16'h0001;
    for (int k = 0; (k < 100) && (cap_d.size() <= rd); k++) tick;
    cnt_value = 16'hFFFF;
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A,
              8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    check_frame("t4", 12, 2'b01, 2'b01, 800);
    chk("t4_no_idle", {31'h0, idle_seen}, 32'h0);
    wait_idle("t4_idle");

    // T5: first tx_start ignored by the model, same byte re-issued
    ignore_at = n_starts;
    cnt_value = 16'h0002;
    r5 = rd;
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h32, 8'h0D, 8'h0A};
    check_frame("t5", 7, 2'b01, 2'b01, 3000);
    if (cap_c.size() >= r5 + 2) begin
      gap = cap_c[r5 + 1] - cap_c[r5];
      chk("t5_reissue_gap", {31'h0, (gap >= ACK + 1) && (gap <= ACK + 2)}, 32'h1);
    end
    wait_idle("t5_idle");

    // T6: reset in the middle of a message, then a clean restart
    cnt_en = 1'b0;
    tick;
    msg_req = 1'b1;
    for (int k = 0; (k < 400) && (cap_d.size() < rd + 5); k++) tick;
    chk("t6_pre_count", 32'(cap_d.size() - rd), 32'd5);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx_start",   {31'h0, tx.tx_start}, 32'h0);
    chk("t6_rst_tx_data",    {24'h0, tx.tx_data}, 32'h0);
    chk("t6_rst_grant",      {30'h0, grant}, 32'h0);
    chk("t6_rst_sched_busy", {31'h0, sched_busy}, 32'h0);
    msg_req = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    rd = cap_d.size();
    msg_req = 1'b1;
    exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
              8'h52, 8'h4C, 8'h44, 8'h20, 8'h21, 8'h21, 8'h21, 8'h21};
    check_frame("t6", 16, 2'b10, 2'b10, 600);
    msg_req = 1'b0;
    wait_idle("t6_idle");

    chk("single_cycle_start", 32'(dbl), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
